alu_share_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU between two requesters, e.g. the integer pipeline (port 0) and the address/debug unit (port 1).
- Each requester sends an operand pair and a 3-bit function code on a valid/ready channel and gets the result and zero flag back on a valid/ready channel.
- Round-robin arbitration; one operation in flight at a time.
- The block drives the ALU's a/b/f inputs and samples its y/zero outputs; the ALU is instantiated beside it in the datapath.

---
 rtl/alu_share_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Time-shares one combinational ALU between two requesters. Each requester
//   presents an operand pair and a 3-bit function code on a valid/ready
//   request channel. It receives the ALU result and zero flag on a
//   valid/ready response channel. Arbitration is round-robin, and only one
//   operation is in flight at a time. Each operation runs IDLE -> EXEC ->
//   RESP -> IDLE.
//
// Ports:
//   clk                 system clock, rising-edge active
//   reset_n             asynchronous active-low reset
//   req_valid[1:0]      request valid, bit i = requester i
//   req_a0/req_a1       operand a for requester 0 / 1
//   req_b0/req_b1       operand b for requester 0 / 1
//   req_f0/req_f1       ALU function code for requester 0 / 1 (passed through)
//   req_ready[1:0]      request accept; at most one bit set, only in IDLE
//   rsp_valid[1:0]      response valid, only the owner's bit, only in RESP
//   rsp_y               captured ALU result (shared, qualified by rsp_valid)
//   rsp_zero            captured ALU zero flag (qualified by rsp_valid)
//   rsp_ready[1:0]      response accept; only the owner's bit is looked at
//   alu_a/alu_b/alu_f   ALU inputs, non-zero only during EXEC
//   alu_y/alu_zero      ALU outputs, sampled at the end of EXEC
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  input  logic [2:0]   req_f0,
  input  logic [2:0]   req_f1,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  output logic [W-1:0] rsp_y,
  output logic         rsp_zero,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_f,
  input  logic [W-1:0] alu_y,
  input  logic         alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q;
  logic         owner_q;
  logic         last_grant_q;
  // Low until the first clock after reset is released. This keeps req_ready
  // at 0 while reset is held, even though the state is already IDLE.
  logic         armed_q;
  // The operand/function registers feed the ALU directly. They are loaded
  // on accept and cleared when EXEC ends, so the ALU sees zero outside EXEC.
  logic [W-1:0] alu_a_q;
  logic [W-1:0] alu_b_q;
  logic [2:0]   alu_f_q;
  logic [W-1:0] y_q;
  logic         zero_q;
  logic [1:0]   rsp_valid_q;

  logic         grant_d;
  logic         accept_d;
  logic         rsp_done_d;
  logic [W-1:0] sel_a_d;
  logic [W-1:0] sel_b_d;
  logic [2:0]   sel_f_d;

  // ---------------------------------------------------------------------------
  // Round-robin grant and request accept.
  // ---------------------------------------------------------------------------
  // A lone request is granted directly. When both requesters are valid,
  // the one that was not served last wins.
  always_comb begin
    grant_d = 1'b0;
    unique case (req_valid)
      2'b01:   grant_d = 1'b0;
      2'b10:   grant_d = 1'b1;
      2'b11:   grant_d = ~last_grant_q;
      default: grant_d = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && armed_q && (req_valid != 2'b00)) begin
      req_ready[grant_d] = 1'b1;
    end
  end

  // The ready bit is only raised for a valid requester, so any ready bit
  // means a handshake takes place.
  assign accept_d = |(req_ready & req_valid);

  always_comb begin
    sel_a_d = grant_d ? req_a1 : req_a0;
    sel_b_d = grant_d ? req_b1 : req_b0;
    sel_f_d = grant_d ? req_f1 : req_f0;
  end

  // Only the owner's rsp_valid bit is ever set. Masking with rsp_ready
  // therefore ignores the non-owner's ready.
  assign rsp_done_d = |(rsp_valid_q & rsp_ready);

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      armed_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_f_q      <= '0;
      y_q          <= '0;
      zero_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            alu_a_q <= sel_a_d;
            alu_b_q <= sel_b_d;
            alu_f_q <= sel_f_d;
            owner_q <= grant_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // The ALU is purely combinational. Its output is settled by the
          // end of the single EXEC cycle.
          y_q         <= alu_y;
          zero_q      <= alu_zero;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_f_q     <= '0;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          // Round-robin history advances only when the result is consumed.
          // A stalled response therefore does not change who goes next.
          if (rsp_done_d) begin
            rsp_valid_q  <= 2'b00;
            last_grant_q <= owner_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_f_q     <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are direct register copies.
  // ---------------------------------------------------------------------------
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = y_q;
  assign rsp_zero  = zero_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed-vector bench for alu_share_arbiter, built around a behavioural ALU.
// The stimulus pushes hand-computed responses into a scoreboard queue in the
// order arbitration should serve them. A monitor pops one entry per response
// handshake and compares it with what the DUT returned.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]  f0 = '0, f1 = '0;
  logic        rr0 = 1'b1, rr1 = 1'b1;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_y;
  logic        rsp_zero;
  logic [1:0]  rsp_ready;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;
  logic        alu_zero;

  assign req_valid = {v1, v0};
  assign rsp_ready = {rr1, rr0};

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_a0    (a0),
    .req_a1    (a1),
    .req_b0    (b0),
    .req_b1    (b1),
    .req_f0    (f0),
    .req_f1    (f1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_ready (rsp_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero)
  );

  // Behavioural ALU that sits beside the arbiter.
  always_comb begin
    case (alu_f)
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a | alu_b;
      3'b010:  alu_y = alu_a + alu_b;
      3'b100:  alu_y = alu_a & ~alu_b;
      3'b101:  alu_y = alu_a | ~alu_b;
      3'b110:  alu_y = alu_a - alu_b;
      3'b111:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = 32'd0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  typedef struct {
    int          port;
    logic [31:0] y;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [31:0] y, input logic z);
    exp_t e;
    e.port = p;
    e.y    = y;
    e.z    = z;
    sb.push_back(e);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Raise valid for port p and wait for the handshake. The task returns
  // 1 time unit after the accepting edge, which is inside the EXEC cycle.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f);
    if (p == 0) begin a0 = a; b0 = b; f0 = f; v0 = 1'b1; end
    else        begin a1 = a; b1 = b; f1 = f; v1 = 1'b1; end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        @(posedge clk);
        #1;
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
        $display("req  port=%0d a=0x%08h b=0x%08h f=%03b accepted", p, a, b, f);
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL issue_timeout port=%0d: got no req_ready, expected accept within 100 cycles", p);
    if (p == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_y"},     rsp_y,          32'd0);
    chk({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
    chk({tag, "_alu_a"},     alu_a,          32'd0);
    chk({tag, "_alu_b"},     alu_b,          32'd0);
    chk({tag, "_alu_f"},     32'(alu_f),     32'd0);
  endtask

  // Response monitor. It pops the scoreboard on each response handshake,
  // checks that a stalled response holds its value, and checks that no
  // request is accepted while a response is pending.
  initial begin
    logic        held;
    logic [31:0] hold_y;
    int          p;
    exp_t        e;
    held = 1'b0;
    hold_y = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
      end else if (rsp_valid != 2'b00) begin
        chk("rsp_valid_onehot", 32'($countones(rsp_valid)), 32'd1);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        p = rsp_valid[1] ? 1 : 0;
        if (held) chk("rsp_y_stable", rsp_y, hold_y);
        if (rsp_ready[p]) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got response port=%0d y=0x%08h, expected none", p, rsp_y);
          end else begin
            e = sb.pop_front();
            $display("rsp  port=%0d y=0x%08h zero=%0b", p, rsp_y, rsp_zero);
            chk("rsp_port", 32'(p), 32'(e.port));
            chk("rsp_y", rsp_y, e.y);
            chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
          end
        end else begin
          held = 1'b1;
          hold_y = rsp_y;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset. Requesting during reset must not be accepted.
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    v0 = 1'b1;
    #1 chk("por_req_ready_valid", 32'(req_ready), 32'd0);
    v0 = 1'b0;
    sync();
    sync();
    reset_n = 1'b1;
    sync();

    // Single add on requester 0: check latency and the EXEC-only ALU drive.
    push(0, 32'd8, 1'b0);
    issue(0, 32'd5, 32'd3, 3'b010);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd3);
    chk("exec_alu_f", 32'(alu_f), 32'd2);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    sync();
    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_alu_a", alu_a, 32'd0);
    chk("resp_alu_f", 32'(alu_f), 32'd0);
    drain();
    sync();

    // Subtract to zero on requester 1.
    push(1, 32'd0, 1'b1);
    issue(1, 32'h1234, 32'h1234, 3'b110);
    drain();
    sync();

    // Reset pulse, then both requesters contend from reset: order 0,1,0,1.
    reset_n = 1'b0;
    #1 check_reset_outputs("pulse");
    sync();
    reset_n = 1'b1;
    sync();
    push(0, 32'h0000_00F0, 1'b0);
    push(1, 32'h0000_FFF0, 1'b0);
    push(0, 32'h0000_00F0, 1'b0);
    push(1, 32'h0000_FFF0, 1'b0);
    fork
      begin
        issue(0, 32'hF0F0, 32'h0FF0, 3'b000);
        issue(0, 32'hF0F0, 32'h0FF0, 3'b000);
      end
      begin
        issue(1, 32'hF0F0, 32'h0FF0, 3'b001);
        issue(1, 32'hF0F0, 32'h0FF0, 3'b001);
      end
    join
    drain();
    sync();

    // Backpressure: requester 0 stalls its response for 4 cycles while
    // requester 1 waits. Requester 1 is served only after the handshake.
    push(0, 32'd123, 1'b0);
    push(1, 32'h0000_000F, 1'b0);
    fork
      issue(0, 32'd100, 32'd23, 3'b010);
      issue(1, 32'h0000_00FF, 32'h0000_000F, 3'b000);
      begin
        rr0 = 1'b0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (rsp_valid[0]) break;
        end
        repeat (4) @(posedge clk);
        #1 rr0 = 1'b1;
      end
    join
    drain();
    sync();

    // SLT: -1 < 1 (signed), so the result is 1.
    push(0, 32'd1, 1'b0);
    issue(0, 32'hFFFF_FFFF, 32'd1, 3'b111);
    drain();
    sync();

    // Reset during EXEC: the operation is dropped, and round-robin
    // history returns to favouring requester 0.
    issue(1, 32'd7, 32'd9, 3'b010);
    chk("exec2_alu_a", alu_a, 32'd7);
    chk("exec2_alu_b", alu_b, 32'd9);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("exec_rst");
    sync();
    sync();
    reset_n = 1'b1;
    repeat (8) sync();
    push(0, 32'd6, 1'b0);
    push(1, 32'd7, 1'b0);
    fork
      issue(0, 32'd10, 32'd4, 3'b110);
      issue(1, 32'd3, 32'd4, 3'b001);
    join
    drain();
    repeat (3) sync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
